// File: rtl/diag_matrix_loader.sv
// Sequential diagonal-matrix generator.
// Fills one diagonal of a ROWS x COLS matrix, either from a single broadcast
// scalar or from one streamed element per diagonal position. The finished
// matrix is held behind a valid/ready output handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. in_ready and out_valid are decoded only
// from the state register (in_ready is additionally forced low while rst is
// high), so neither depends combinationally on in_valid or out_ready.
// out_valid never drops without a completed out handshake, except on reset.
module diag_matrix_loader #(
  parameter  int BIT_WIDTH = 4,
  parameter  int ROWS      = 8,
  parameter  int COLS      = 8,
  localparam int OFF_W     = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int CNT_W     = ($clog2(ROWS + 1) > 1) ? $clog2(ROWS + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [OFF_W-1:0]     offset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out [ROWS-1:0][COLS-1:0],
  output logic                 dbg_state
);

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [OFF_W-1:0]     eoff_q, eoff_d;
  logic [BIT_WIDTH-1:0] out_q [ROWS-1:0][COLS-1:0];
  logic [BIT_WIDTH-1:0] out_d [ROWS-1:0][COLS-1:0];

  logic                 accept;
  logic                 first;
  logic [OFF_W-1:0]     off_clamp;
  logic                 frame_mode;
  logic [OFF_W-1:0]     frame_eoff;
  int                   frame_len;

  assign in_ready  = (state_q == LOAD) && !rst;
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign first     = (cnt_q == '0);
  assign out       = out_q;
  assign dbg_state = state_q;

  // Clamp the port offset to the last column and pick the frame's mode/offset:
  // the live ports on the first element, the latched copies afterwards.
  always_comb begin
    off_clamp = offset;
    if (int'(offset) > COLS - 1) begin
      off_clamp = OFF_W'(COLS - 1);
    end
    frame_mode = first ? mode : mode_q;
    frame_eoff = first ? off_clamp : eoff_q;
    frame_len  = COLS - int'(frame_eoff);
    if (frame_len > ROWS) begin
      frame_len = ROWS;
    end
  end

  // Next-state, counter, latched-control and matrix-contents logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    eoff_d  = eoff_q;
    out_d   = out_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (first) begin
            mode_d = mode;
            eoff_d = off_clamp;
          end
          if (!frame_mode) begin
            // Broadcast: every in-range diagonal position gets the scalar.
            for (int r = 0; r < ROWS; r++) begin
              for (int c = 0; c < COLS; c++) begin
                if (c == r + int'(frame_eoff)) begin
                  out_d[r][c] = in_data;
                end
              end
            end
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            // Stream: element cnt lands at (cnt, cnt + eoff).
            for (int r = 0; r < ROWS; r++) begin
              for (int c = 0; c < COLS; c++) begin
                if ((r == int'(cnt_q)) && (c == r + int'(frame_eoff))) begin
                  out_d[r][c] = in_data;
                end
              end
            end
            if (int'(cnt_q) == frame_len - 1) begin
              state_d = HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              out_d[r][c] = '0;
            end
          end
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State, counter, latched controls and matrix registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      eoff_q  <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          out_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      eoff_q  <= eoff_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: doc/diag_matrix_loader.md
# diag_matrix_loader

Sequential, parametrised generator of diagonal matrices for the array-operations library. Builds a ROWS×COLS matrix whose only non-zero elements lie on one diagonal, selectable by column offset. The diagonal is filled either by broadcasting one scalar or by streaming one element per handshake. The finished matrix is held behind a valid/ready output handshake, so matrix-consuming blocks can take generated identity/scaling/band matrices without combinational fan-out from a scalar.

## Interface
- BIT_WIDTH, 4, element width in bits
- ROWS, 8, matrix rows (≥1)
- COLS, 8, matrix columns (≥1)
- OFF_W (derived, not overridable), max(1, $clog2(COLS)), offset field width
- CNT_W (derived), max(1, $clog2(ROWS+1)), element counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- mode  in  1  0 = broadcast one scalar, 1 = stream one element per diagonal position
- offset  in  OFF_W  diagonal column offset; element k lands at (k, k+offset)
- in_valid  in  1  input element valid
- in_ready  out  1  block can accept an element
- in_data  in  BIT_WIDTH  input element
- out_valid  out  1  matrix complete and stable
- out_ready  in  1  consumer accepts matrix
- out  out  BIT_WIDTH  unpacked [ROWS-1:0][COLS-1:0], registered matrix

## Operation
- Effective offset: eoff = min(offset, COLS-1). Diagonal length L = min(ROWS, COLS-eoff), always ≥1.
- mode and offset are sampled on the frame's first accepted element (cnt==0 handshake) and held in registers for the rest of the frame. Mid-frame changes on the ports are ignored.
- State LOAD: in_ready=1, out_valid=0.
  - Broadcast (latched mode=0): the first handshake writes in_data to every (k, k+eoff) for k<L. All other elements stay 0. Next state is HOLD.
  - Stream (latched mode=1): handshake number k (0-based, cnt=k) writes in_data to (k, k+eoff) and increments cnt. The handshake with cnt==L-1 moves the block to HOLD and resets cnt to 0.
- State HOLD: in_ready=0, out_valid=1, and out is frozen.
  - If out_ready=1, every element of out clears to 0 on that edge and the next state is LOAD.
  - If out_ready=0, the block stays in HOLD with out unchanged.
- Off-diagonal elements are never written non-zero. In stream mode, in_data=0 is written as 0; there is no special case.
- During LOAD, out shows the partially built matrix. Consumers qualify it with out_valid only.
- Reset, including mid-frame or during HOLD: state=LOAD, cnt=0, all out elements 0, out_valid=0, latched mode/offset=0. While rst is high, in_ready is forced to 0 and handshakes are ignored.
- Non-square cases: ROWS>COLS leaves rows L..ROWS-1 all zero. An offset>0 shortens L as defined above.

## Timing
- in_ready=1 in the first cycle after rst deasserts.
- Broadcast latency: handshake at edge t gives out_valid=1 from t+1 and in_ready=0 from t+1.
- Stream latency: the L-th handshake at edge t gives out_valid=1 from t+1. Non-consecutive in_valid simply stalls the frame, with no timeout.
- out_valid/out_ready handshake at edge t gives out_valid=0, out all zero and in_ready=1 from t+1. A new element can be accepted in that cycle. Maximum throughput is therefore one broadcast matrix per 2 cycles, or one stream matrix per L+1 cycles.
- out_valid never drops without an out_ready handshake, except on reset. out is stable for every cycle out_valid=1.
- All outputs are registered or decoded from the state register. There is no combinational path from in_valid/out_ready to in_ready/out_valid.

## Test plan
- Reset/identity: ROWS=COLS=8, hold rst 3 cycles mid-stream after 4 elements. Then broadcast mode=0, offset=0, in_data=1. Required: out all 0 and out_valid=0 after reset; one cycle after the handshake, out[i][i]=1 for i=0..7, all else 0, out_valid=1.
- Stream with offset: ROWS=4, COLS=6, mode=1, offset=2, stream 5,6,7,8. Required: L=4; out[0][2]=5, out[1][3]=6, out[2][4]=7, out[3][5]=8, everything else 0; out_valid rises exactly one cycle after the 4th handshake.
- Offset clamp/short diagonal: ROWS=COLS=8, stream mode, offset=7. Required: a single handshake (value 9) completes the frame; out[0][7]=9, out_valid next cycle.
- Output backpressure: hold out_ready=0 for 10 cycles in HOLD with in_valid=1, in_data toggling. Required: in_ready=0, out unchanged and out_valid=1 throughout. Release out_ready: next cycle out all 0, in_ready=1.
- Latch check: change mode 1→0 and offset 0→3 after the 2nd of 8 stream elements (ROWS=COLS=8). Required: the frame completes as mode=1, offset=0 after 8 handshakes, with element k at (k,k).
- Back-to-back frames: 100 random frames (random mode/offset/data/valid gaps/out_ready) against a scoreboard. Required: every held matrix matches the model, and no handshake is lost or duplicated.
